// File: rtl/gradient_kernel_pipe.sv
// 3x3 gradient engine (Sobel / Prewitt / Scharr) with a 3-stage valid/ready pipeline,
// per-frame shadowed configuration, saturated L1 magnitude and saturation counter.
`timescale 1ns/1ps
module gradient_kernel_pipe #(
    parameter int PIXEL_WIDTH = 8,
    parameter int GRAD_WIDTH  = PIXEL_WIDTH + 5,
    parameter int CNT_WIDTH   = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [9*PIXEL_WIDTH-1:0]     in_window,
    input  logic                         in_sof,
    input  logic                         in_eol,
    input  logic [1:0]                   cfg_mode,
    input  logic [1:0]                   cfg_shift,
    input  logic [PIXEL_WIDTH-1:0]       cfg_thresh,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [GRAD_WIDTH-1:0] out_gx,
    output logic signed [GRAD_WIDTH-1:0] out_gy,
    output logic [PIXEL_WIDTH-1:0]       out_mag,
    output logic                         out_edge,
    output logic                         out_sof,
    output logic                         out_eol,
    output logic [CNT_WIDTH-1:0]         sat_count
);
    localparam int PW = PIXEL_WIDTH;
    localparam int GW = GRAD_WIDTH;
    localparam int DW = PIXEL_WIDTH + 2;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_SCHARR  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    mode_t                mode_sh;
    logic [1:0]           shift_sh;
    logic [PW-1:0]        thresh_sh;

    logic                 v1, v2;
    logic signed [DW-1:0] dx1 [3];
    logic signed [DW-1:0] dy1 [3];
    mode_t                mode1;
    logic [1:0]           shift1, shift2;
    logic [PW-1:0]        thresh1, thresh2;
    logic                 sof1, eol1, sof2, eol2;
    logic signed [GW-1:0] gx2, gy2;
    logic                 mag_sat;

    logic load1, load2, load3, accept, take_cfg;
    assign load3    = !out_valid || out_ready;
    assign load2    = !v2 || load3;
    assign load1    = !v1 || load2;
    assign in_ready = load1;
    assign accept   = in_valid && load1;
    assign take_cfg = accept && in_sof;

    // The sof beat itself already uses the freshly presented configuration.
    mode_t         mode_in;
    logic [1:0]    shift_in;
    logic [PW-1:0] thresh_in;
    assign mode_in   = take_cfg ? mode_t'(cfg_mode) : mode_sh;
    assign shift_in  = take_cfg ? cfg_shift : shift_sh;
    assign thresh_in = take_cfg ? cfg_thresh : thresh_sh;

    logic [PW-1:0] p [9];
    always_comb begin
        for (int unsigned i = 0; i < 9; i++) p[i] = in_window[i*PW +: PW];
    end

    function automatic logic signed [DW-1:0] diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return $signed({2'b00, a}) - $signed({2'b00, b});
    endfunction

    function automatic logic signed [GW-1:0] sext(input logic signed [DW-1:0] d);
        return {{(GW-DW){d[DW-1]}}, d};
    endfunction

    function automatic logic signed [GW-1:0] weigh(input logic signed [DW-1:0] e0,
                                                   input logic signed [DW-1:0] e1,
                                                   input logic signed [DW-1:0] e2,
                                                   input mode_t m);
        logic signed [GW-1:0] outer, centre;
        outer  = sext(e0) + sext(e2);
        centre = sext(e1);
        case (m)
            MODE_PREWITT: return outer + centre;
            MODE_SCHARR:  return (outer <<< 1) + outer + (centre <<< 3) + (centre <<< 1);
            default:      return outer + (centre <<< 1);
        endcase
    endfunction

    logic signed [GW:0] gxe, gye;
    logic [GW:0]        ax, ay, sum, shifted;
    logic               sat_n;
    logic [PW-1:0]      mag_n;
    always_comb begin
        gxe     = {gx2[GW-1], gx2};
        gye     = {gy2[GW-1], gy2};
        ax      = gxe[GW] ? -gxe : gxe;
        ay      = gye[GW] ? -gye : gye;
        sum     = ax + ay;
        shifted = sum >> shift2;
        sat_n   = |shifted[GW:PW];
        mag_n   = sat_n ? '1 : shifted[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sh   <= MODE_SOBEL;
            shift_sh  <= '0;
            thresh_sh <= '1;
            v1 <= 1'b0; v2 <= 1'b0; out_valid <= 1'b0;
            dx1 <= '{default: '0};
            dy1 <= '{default: '0};
            mode1 <= MODE_SOBEL; shift1 <= '0; thresh1 <= '0; sof1 <= 1'b0; eol1 <= 1'b0;
            gx2 <= '0; gy2 <= '0; shift2 <= '0; thresh2 <= '0; sof2 <= 1'b0; eol2 <= 1'b0;
            out_gx <= '0; out_gy <= '0; out_mag <= '0; out_edge <= 1'b0;
            out_sof <= 1'b0; out_eol <= 1'b0; mag_sat <= 1'b0;
            sat_count <= '0;
        end else begin
            if (take_cfg) begin
                mode_sh   <= mode_t'(cfg_mode);
                shift_sh  <= cfg_shift;
                thresh_sh <= cfg_thresh;
            end
            if (load1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    dx1[0] <= diff(p[2], p[0]);
                    dx1[1] <= diff(p[5], p[3]);
                    dx1[2] <= diff(p[8], p[6]);
                    dy1[0] <= diff(p[6], p[0]);
                    dy1[1] <= diff(p[7], p[1]);
                    dy1[2] <= diff(p[8], p[2]);
                    mode1 <= mode_in; shift1 <= shift_in; thresh1 <= thresh_in;
                    sof1 <= in_sof; eol1 <= in_eol;
                end
            end
            if (load2) begin
                v2 <= v1;
                if (v1) begin
                    gx2 <= weigh(dx1[0], dx1[1], dx1[2], mode1);
                    gy2 <= weigh(dy1[0], dy1[1], dy1[2], mode1);
                    shift2 <= shift1; thresh2 <= thresh1;
                    sof2 <= sof1; eol2 <= eol1;
                end
            end
            if (load3) begin
                out_valid <= v2;
                if (v2) begin
                    out_gx <= gx2; out_gy <= gy2;
                    out_mag <= mag_n; out_edge <= (mag_n >= thresh2);
                    mag_sat <= sat_n;
                    out_sof <= sof2; out_eol <= eol2;
                end
            end
            if (out_valid && out_ready) begin
                if (out_sof)
                    sat_count <= {{(CNT_WIDTH-1){1'b0}}, mag_sat};
                else if (mag_sat && !(&sat_count))
                    sat_count <= sat_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gradient_kernel_pipe.sv
// Directed bench for gradient_kernel_pipe: kernel values, shift/threshold edges,
// backpressure ordering, mid-frame config changes and reset while stalled.
`timescale 1ns/1ps
module tb_gradient_kernel_pipe;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [71:0]        in_window = '0;
    logic               in_sof = 1'b0;
    logic               in_eol = 1'b0;
    logic [1:0]         cfg_mode = 2'd0;
    logic [1:0]         cfg_shift = 2'd0;
    logic [7:0]         cfg_thresh = 8'd0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [12:0] out_gx, out_gy;
    logic [7:0]         out_mag;
    logic               out_edge, out_sof, out_eol;
    logic [19:0]        sat_count;

    gradient_kernel_pipe #(.PIXEL_WIDTH(8), .GRAD_WIDTH(13), .CNT_WIDTH(20)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .in_sof(in_sof), .in_eol(in_eol),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift), .cfg_thresh(cfg_thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_gx(out_gx), .out_gy(out_gy),
        .out_mag(out_mag), .out_edge(out_edge), .out_sof(out_sof), .out_eol(out_eol),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mk(input int p0, input int p1, input int p2,
                                       input int p3, input int p4, input int p5,
                                       input int p6, input int p7, input int p8);
        return {p8[7:0], p7[7:0], p6[7:0], p5[7:0], p4[7:0], p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endfunction

    int o_gx, o_gy, o_mag, o_edge, o_sof, o_eol, lat;

    // One beat through an otherwise idle pipe; captures the result, then lets it transfer.
    task automatic beat(input logic [71:0] w, input logic sof, input logic [1:0] mode,
                        input logic [1:0] shift, input logic [7:0] th);
        in_window = w; in_sof = sof; in_eol = 1'b0;
        cfg_mode = mode; cfg_shift = shift; cfg_thresh = th;
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        o_gx = int'(out_gx); o_gy = int'(out_gy); o_mag = int'(out_mag);
        o_edge = int'(out_edge); o_sof = int'(out_sof); o_eol = int'(out_eol);
        @(negedge clk);
    endtask

    int j, k, inflight, cyc, acc, xfer;
    logic stalled;
    int s_gx, s_mag, s_sof;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_gx", out_gx, 0);
        check("rst_sat_count", sat_count, 0);

        beat(mk(100,100,100, 100,100,100, 100,100,100), 1'b1, 2'd0, 2'd0, 8'd50);
        check("flat_latency", lat, 3);
        check("flat_gx", o_gx, 0);
        check("flat_gy", o_gy, 0);
        check("flat_mag", o_mag, 0);
        check("flat_edge", o_edge, 0);
        check("flat_sof", o_sof, 1);

        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd0, 2'd0, 8'd255);
        check("vstep_sobel_gx", o_gx, 1020);
        check("vstep_sobel_gy", o_gy, 0);
        check("vstep_sobel_mag", o_mag, 255);
        check("vstep_sobel_edge", o_edge, 1);
        check("vstep_sobel_satcnt", sat_count, 1);

        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd1, 2'd0, 8'd255);
        check("vstep_prewitt_gx", o_gx, 765);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd2, 2'd0, 8'd255);
        check("vstep_scharr_gx", o_gx, 4080);
        check("vstep_scharr_mag", o_mag, 255);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd3, 2'd2, 8'd255);
        check("vstep_mode3_gx", o_gx, 1020);
        check("vstep_shift2_mag", o_mag, 255);
        check("vstep_shift2_nosat", sat_count, 0);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd0, 2'd3, 8'd255);
        check("vstep_shift3_mag", o_mag, 127);

        beat(mk(0,0,40, 0,0,40, 0,0,40), 1'b1, 2'd0, 2'd0, 8'd160);
        check("step40_gx", o_gx, 160);
        check("step40_mag", o_mag, 160);
        check("step40_edge_160", o_edge, 1);
        beat(mk(0,0,40, 0,0,40, 0,0,40), 1'b1, 2'd0, 2'd0, 8'd161);
        check("step40_edge_161", o_edge, 0);

        beat(mk(0,0,0, 0,0,0, 200,200,200), 1'b1, 2'd0, 2'd0, 8'd255);
        check("hstep_gy", o_gy, 800);
        check("hstep_gx", o_gx, 0);
        beat(mk(200,200,200, 0,0,0, 0,0,0), 1'b1, 2'd0, 2'd0, 8'd255);
        check("hstep_mirror_gy", o_gy, -800);
        check("hstep_mirror_mag", o_mag, 255);

        // Backpressure: out_ready pattern 1,0,0 repeating; vstep amplitude j+1 gives gx=4*(j+1).
        cfg_mode = 2'd0; cfg_shift = 2'd0; cfg_thresh = 8'd30;
        j = 0; k = 0; inflight = 0; cyc = 0; stalled = 1'b0;
        s_gx = 0; s_mag = 0; s_sof = 0;
        while (k < 16 && cyc < 300) begin
            if (stalled) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_gx", out_gx, s_gx);
                check("bp_hold_mag", out_mag, s_mag);
                check("bp_hold_sof", out_sof, s_sof);
            end
            out_ready = (cyc % 3 == 0);
            in_valid  = (j < 16);
            in_window = mk(0,0,j+1, 0,0,j+1, 0,0,j+1);
            in_sof    = (j == 0);
            in_eol    = (j % 4 == 3);
            #1;
            check("bp_in_ready", in_ready, !(inflight == 3 && !out_ready));
            acc  = int'(in_valid && in_ready);
            xfer = int'(out_valid && out_ready);
            if (xfer != 0) begin
                check("bp_gx", out_gx, 4*(k+1));
                check("bp_gy", out_gy, 0);
                check("bp_mag", out_mag, 4*(k+1));
                check("bp_edge", out_edge, int'(4*(k+1) >= 30));
                check("bp_sof", out_sof, int'(k == 0));
                check("bp_eol", out_eol, int'(k % 4 == 3));
                k++;
            end
            j += acc;
            inflight += acc - xfer;
            stalled = out_valid && !out_ready;
            s_gx = int'(out_gx); s_mag = int'(out_mag); s_sof = int'(out_sof);
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
        check("bp_result_count", k, 16);
        check("bp_accept_count", j, 16);
        @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Mode change mid-frame only takes effect at the next sof.
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd0, 2'd0, 8'd255);
        check("mid_sof_gx", o_gx, 1020);
        check("mid_sof_satcnt", sat_count, 1);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b0, 2'd2, 2'd0, 8'd255);
        check("mid_nonsof_gx", o_gx, 1020);
        check("mid_nonsof_satcnt", sat_count, 2);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b0, 2'd2, 2'd0, 8'd255);
        check("mid_nonsof2_satcnt", sat_count, 3);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b1, 2'd2, 2'd0, 8'd255);
        check("mid_next_sof_gx", o_gx, 4080);
        check("mid_next_sof_satcnt", sat_count, 1);

        // Fill the stalled pipe with Scharr beats, then reset.
        out_ready = 1'b0;
        in_window = mk(0,0,255, 0,0,255, 0,0,255);
        cfg_mode = 2'd2; cfg_shift = 2'd1; cfg_thresh = 8'd10;
        in_sof = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0;
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_gx", out_gx, 0);
        check("mrst_gy", out_gy, 0);
        check("mrst_mag", out_mag, 0);
        check("mrst_edge", out_edge, 0);
        check("mrst_sof", out_sof, 0);
        check("mrst_sat_count", sat_count, 0);
        @(negedge clk);
        beat(mk(0,0,255, 0,0,255, 0,0,255), 1'b0, 2'd2, 2'd1, 8'd10);
        check("post_rst_mode_gx", o_gx, 1020);
        beat(mk(0,0,40, 0,0,40, 0,0,40), 1'b0, 2'd2, 2'd1, 8'd10);
        check("post_rst_shift_mag", o_mag, 160);
        check("post_rst_thresh_edge", o_edge, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gradient_kernel_pipe.md
# gradient_kernel_pipe

Parametrised, multi-mode 3x3 gradient engine for the edge-detection datapath. Consumes one 3x3 window per accepted beat from the line buffer and produces signed Gx/Gy, a saturated L1 magnitude, an edge flag and frame sideband through a 3-stage pipeline with full valid/ready backpressure. Supports Sobel, Prewitt and Scharr kernels, selected per frame. Also keeps a per-frame count of saturated magnitudes. Replaces the fixed Sobel-only stage that has no backpressure.

## Interface
- PIXEL_WIDTH, 8, unsigned pixel and magnitude width
- GRAD_WIDTH, PIXEL_WIDTH+5, signed gradient width; must be >= PIXEL_WIDTH+5 (holds Scharr +/-16*max)
- CNT_WIDTH, 20, saturation counter width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  window beat valid
- in_ready  out  1  block can accept a beat
- in_window  in  9*PIXEL_WIDTH  p0 in LSBs … p8 in MSBs, row-major, p0 top-left, p4 centre
- in_sof  in  1  beat is first pixel of frame
- in_eol  in  1  beat is last pixel of line
- cfg_mode  in  2  0 Sobel, 1 Prewitt, 2 Scharr, 3 treated as Sobel
- cfg_shift  in  2  magnitude right-shift before saturation
- cfg_thresh  in  PIXEL_WIDTH  edge threshold
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_gx, out_gy  out  GRAD_WIDTH each  signed gradients
- out_mag  out  PIXEL_WIDTH  saturated magnitude
- out_edge  out  1  out_mag >= cfg_thresh (latched copy)
- out_sof, out_eol  out  1 each  sideband aligned with result
- sat_count  out  CNT_WIDTH  saturated magnitudes in current frame

## Operation
- Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
- Config latch: cfg_mode, cfg_shift and cfg_thresh are captured into shadow registers on an accepted beat with in_sof=1. That beat and all later beats use the new values. Changes mid-frame have no effect until the next accepted sof. After reset the shadows are Sobel, shift 0, thresh all-ones.
- Kernels (weights a,b): Sobel (1,2), Prewitt (1,1), Scharr (3,10).
  - Gx = a*(p2-p0) + b*(p5-p3) + a*(p8-p6)
  - Gy = a*(p6-p0) + b*(p7-p1) + a*(p8-p2)
  - All pixels are zero-extended to signed. Use shift-add only; no multipliers.
- Stage S1: register the column and row differences, sign-extended to PIXEL_WIDTH+2 bits, plus the latched mode.
- Stage S2: apply the weights and register gx, gy at GRAD_WIDTH.
- Stage S3:
  - sum = |gx| + |gy| at GRAD_WIDTH+1 bits, then `>> shift`.
  - If any bit at or above PIXEL_WIDTH is set, mag = all-ones and `sat` = 1.
  - edge = mag >= thresh. Register all S3 outputs.
- Each stage carries a valid bit, sof/eol, and the shadowed config that was in force when its beat was accepted.
- sat_count:
  - Clears to 0 when an sof result transfers out, then counts that beat if it is saturated.
  - Otherwise increments on each transferred saturated result.
  - Holds at all-ones, with no wrap.

## Timing
- Latency: an accepted beat appears on out_* 3 cycles after acceptance when no stall occurs.
- Throughput: 1 beat per cycle while out_ready=1.
- Per-stage advance: stage k loads when it is empty or stage k+1 advances (S3 advances when out_ready=1). Bubbles therefore collapse.
- in_ready = !S1.valid || S1 advancing. This is combinational from out_ready through the stage valids. There is no combinational path from in_valid to in_ready.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Reset: all stage valids are 0, in_ready=1 on the first cycle after reset, and every output data register is 0: out_gx, out_gy, out_mag, out_edge, out_sof, out_eol, sat_count. In-flight beats are discarded. Reset mid-stall drops the held result.
- Simultaneous sof acceptance and sof output: the shadow config update and the counter clear act independently and in the same cycle.

## Test plan
- Flat window (all p=100), Sobel -> gx=0, gy=0, mag=0, edge=0, latency 3 cycles.
- Vertical step (p0,p3,p6=0; p2,p5,p8=255):
  - Sobel, shift 0 -> gx=1020, gy=0, mag=255, sat_count=1.
  - Prewitt -> gx=765.
  - Scharr -> gx=4080.
  - Sobel, shift 2 -> mag=255.
  - Sobel with the 0/255 step replaced by 0/40, shift 0 -> gx=160, mag=160, edge=1 at thresh 160, edge=0 at thresh 161.
- Horizontal step (top row 0, bottom row 200), Sobel -> gy=800, gx=0. The mirrored step (top row 200, bottom row 0) -> gy=-800.
- Backpressure: stream 16 beats while toggling out_ready 1,0,0,1,… -> all 16 results appear in order, none dropped or duplicated, outputs stable while stalled, in_ready falls only when the pipe is full.
- Mode change mid-frame: set cfg_mode=2 on a non-sof beat -> results stay Sobel until the next sof beat, which is Scharr. sat_count clears with that sof result.
- Assert rst with 3 beats in flight and out_ready=0 -> the next cycle shows out_valid=0, all outputs 0, sat_count=0, in_ready=1, and the shadow config back to Sobel.
